// File: rtl/rle_pixel_decoder_if.sv
// Token handshake bundle between the flash stream and the RLE pixel decoder.
interface rle_pixel_decoder_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: prefetch FIFO of run/colour tokens expanded into per-pixel colour.
// Optional feature macro RLE_AUDIO_EN: control tokens (run 0, colour != 0) update pwm_sample.
module rle_pixel_decoder #(
  parameter int unsigned COLOUR_BITS = 6,
  parameter int unsigned RUN_BITS    = 10,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rle_pixel_decoder_if.slave     bus,
  input  logic                   next_frame,
  input  logic                   next_pixel,
  output logic                   stream_start,
  output logic                   stream_stop,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   underflow,
  output logic [COLOUR_BITS-1:0] pwm_sample
);

  localparam int unsigned DATA_W = RUN_BITS + COLOUR_BITS;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_e;

  state_e                 state_q, state_d;
  logic [RUN_BITS-1:0]    count_q, count_d;
  logic [COLOUR_BITS-1:0] colour_d;
  logic                   start_d, stop_d, underflow_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];

  logic                   empty, full, ready_c, push, pop, flush, eval;
  logic [DATA_W-1:0]      head;
  logic [RUN_BITS-1:0]    head_run;
  logic [COLOUR_BITS-1:0] head_col;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head     = mem[rd_ptr_q[AW-1:0]];
  assign head_run = head[DATA_W-1:COLOUR_BITS];
  assign head_col = head[COLOUR_BITS-1:0];

  assign ready_c      = (state_q == RUN) && !next_frame && !full;
  assign bus.in_ready = ready_c;
  assign push         = bus.in_valid && ready_c;

`ifdef RLE_AUDIO_EN
  logic [COLOUR_BITS-1:0] pwm_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    colour_d    = colour;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    underflow_d = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    eval        = 1'b0;
`ifdef RLE_AUDIO_EN
    pwm_d       = pwm_sample;
`endif
    case (state_q)
      IDLE, STOPPED: begin
        if (next_frame) begin
          state_d = RUN;
          start_d = 1'b1;
          flush   = 1'b1;
          count_d = '0;
        end
      end
      RUN: begin
        if (next_frame) begin
          start_d = 1'b1;
          flush   = 1'b1;
          count_d = '0;
        end else begin
          // A run ending this cycle hands over to a resident token with no bubble.
          if (next_pixel && (count_q != '0)) begin
            count_d = count_q - RUN_BITS'(1);
            eval    = (count_q == RUN_BITS'(1)) && !empty;
          end else if (count_q == '0) begin
            if (!empty)          eval        = 1'b1;
            else if (next_pixel) underflow_d = 1'b1;
          end
          if (eval) begin
            pop = 1'b1;
            if (head_run != '0) begin
              count_d  = head_run;
              colour_d = head_col;
            end else if (head_col == '0) begin
              state_d  = STOPPED;
              stop_d   = 1'b1;
              colour_d = '0;
            end else begin
`ifdef RLE_AUDIO_EN
              pwm_d = head_col;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      colour       <= '0;
      stream_start <= 1'b0;
      stream_stop  <= 1'b0;
      underflow    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      colour       <= colour_d;
      stream_start <= start_d;
      stream_stop  <= stop_d;
      underflow    <= underflow_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
  end

`ifdef RLE_AUDIO_EN
  always_ff @(posedge clk) begin
    if (rst) pwm_sample <= '0;
    else     pwm_sample <= pwm_d;
  end
`else
  assign pwm_sample = '0;
`endif

endmodule
